// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with a valid/ready handshake on both sides.
// Signed operands are converted to magnitudes on capture, multiplied unsigned
// over WIDTH cycles, and the product is negated on completion when the operand
// signs differ. The operation has a fixed latency of WIDTH cycles from
// acceptance to out_valid.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    // Counter is wide enough to hold the value WIDTH itself.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [2*WIDTH-1:0]   mcand_q,     mcand_d;
    logic [WIDTH-1:0]     mplier_q,    mplier_d;
    logic [2*WIDTH-1:0]   acc_q,       acc_d;
    logic [CW-1:0]        cnt_q,       cnt_d;
    logic                 neg_q,       neg_d;
    logic [2*WIDTH-1:0]   product_q,   product_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q,      busy_d;

    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   step_acc;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1) unsigned.
    always_comb begin
        mag_a = a;
        mag_b = b;
        if (is_signed && a[WIDTH-1]) begin
            mag_a = ~a + 1'b1;
        end
        if (is_signed && b[WIDTH-1]) begin
            mag_b = ~b + 1'b1;
        end
    end

    // Next-state and datapath update for the IDLE/BUSY/DONE controller.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        product_d   = product_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        step_acc    = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mcand_d    = {{WIDTH{1'b0}}, mag_a};
                    mplier_d   = mag_b;
                    acc_d      = '0;
                    cnt_d      = '0;
                    neg_d      = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            BUSY: begin
                acc_d    = step_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    product_d   = neg_q ? (~step_acc + 1'b1) : step_acc;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: a WIDTH=8 instance with directed, random,
// backpressure and reset scenarios, plus WIDTH=2 and WIDTH=16 instances
// exercised with random operands. Expected products come from integer
// multiplication of the sign- or zero-extended operands.
module tb_seq_multiplier;

    typedef struct {
        logic [63:0] prod;
        int          acc_cyc;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sweep_done = 0;
    int bp_req = 0;

    logic clk = 1'b0;

    // Free-running clock and edge counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference product: plain integer multiply of the extended operands.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input bit s);
        longint vx;
        longint vy;
        longint p;
        logic [63:0] mask;
        vx = longint'({32'd0, x});
        vy = longint'({32'd0, y});
        if (s && x[w-1]) vx = vx - (longint'(1) << w);
        if (s && y[w-1]) vy = vy - (longint'(1) << w);
        p = vx * vy;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    // One comparison: counts it and reports a FAIL line on mismatch.
    task automatic check_output(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- WIDTH = 8 instance ----------------
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = 8'd0;
    logic [7:0]  b = 8'd0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] product;
    logic        busy;

    exp_t sb[$];

    seq_multiplier #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // Monitor: pops the scoreboard on each new result, checks stability while
    // held, and drives out_ready (forced low for bp_req cycles per result).
    bit          seen = 1'b0;
    bit          rel_pend = 1'b0;
    logic [15:0] held_prod = '0;
    int          held_cyc = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen     = 1'b0;
            rel_pend = 1'b0;
        end else begin
            if (rel_pend) begin
                check_output("release_to_idle_valid", 64'(out_valid), 64'd0);
                check_output("release_to_idle_ready", 64'(in_ready), 64'd1);
                rel_pend = 1'b0;
            end
            if (out_valid) begin
                check_output("in_ready_in_done", 64'(in_ready), 64'd0);
                check_output("busy_in_done", 64'(busy), 64'd1);
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check_output("unexpected_out_valid", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check_output("product_w8", 64'(product), e.prod);
                        check_output("latency_w8", 64'(cyc - e.acc_cyc), 64'd8);
                    end
                    held_prod = product;
                    held_cyc  = 0;
                    seen      = 1'b1;
                end else begin
                    check_output("product_stable", 64'(product), 64'(held_prod));
                end
                if (held_cyc < bp_req) begin
                    out_ready = 1'b0;
                    held_cyc++;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                if (out_ready) begin
                    seen     = 1'b0;
                    rel_pend = 1'b1;
                end
            end else begin
                out_ready = $urandom_range(0, 1) != 0;
            end
        end
    end

    // Issue one operand pair once in_ready is seen, then scramble the inputs
    // for the whole BUSY phase; they must not disturb the result.
    task automatic apply_stimulus(input logic [7:0] ai, input logic [7:0] bi,
                                  input bit si);
        exp_t e;
        int   g = 0;
        @(negedge clk);
        while (!in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            check_output("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        a         = ai;
        b         = bi;
        is_signed = si;
        in_valid  = 1'b1;
        e.prod    = ref_mul(8, {24'd0, ai}, {24'd0, bi}, si);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        repeat (8) begin
            @(negedge clk);
            a         = 8'($urandom);
            b         = 8'($urandom);
            is_signed = 1'($urandom);
            in_valid  = 1'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait until every issued operation has been consumed and IDLE is back.
    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (!(in_ready && sb.size() == 0) && g < 1000) begin
            @(negedge clk);
            g++;
        end
        check_output("drain_idle", 64'(sb.size()), 64'd0);
    endtask

    // Reset values visible on the ports.
    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_product"}, 64'(product), 64'd0);
    endtask

    // ---------------- WIDTH = 2 and 16 sweep instances ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int W = (g == 0) ? 2 : 16;

        logic             s_rst = 1'b1;
        logic             s_in_valid = 1'b0;
        logic             s_in_ready;
        logic [W-1:0]     s_a = '0;
        logic [W-1:0]     s_b = '0;
        logic             s_is_signed = 1'b0;
        logic             s_out_valid;
        logic             s_out_ready = 1'b0;
        logic [2*W-1:0]   s_product;
        logic             s_busy;
        exp_t             s_sb[$];
        bit               s_seen = 1'b0;

        seq_multiplier #(.WIDTH(W)) dut_s (
            .clk       (clk),
            .rst       (s_rst),
            .in_valid  (s_in_valid),
            .in_ready  (s_in_ready),
            .a         (s_a),
            .b         (s_b),
            .is_signed (s_is_signed),
            .out_valid (s_out_valid),
            .out_ready (s_out_ready),
            .product   (s_product),
            .busy      (s_busy)
        );

        // Random issue of operand pairs with the expected result queued.
        initial begin
            exp_t e;
            int   guard;
            repeat (3) @(negedge clk);
            s_rst = 1'b0;
            for (int n = 0; n < 30; n++) begin
                guard = 0;
                @(negedge clk);
                while (!s_in_ready && guard < 200) begin
                    @(negedge clk);
                    guard++;
                end
                if (!s_in_ready) begin
                    check_output("sweep_ready_timeout", 64'(s_in_ready), 64'd1);
                    break;
                end
                s_a         = W'($urandom);
                s_b         = W'($urandom);
                s_is_signed = 1'($urandom);
                s_in_valid  = 1'b1;
                e.prod      = ref_mul(W, 32'(s_a), 32'(s_b), s_is_signed);
                e.acc_cyc   = cyc + 1;
                s_sb.push_back(e);
                @(negedge clk);
                s_in_valid = 1'b0;
            end
            guard = 0;
            while (s_sb.size() != 0 && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            check_output("sweep_drain", 64'(s_sb.size()), 64'd0);
            sweep_done++;
        end

        // Result checker for the sweep instance with random backpressure.
        always @(negedge clk) begin
            exp_t e;
            if (!s_rst) begin
                if (s_out_valid && !s_seen) begin
                    if (s_sb.size() == 0) begin
                        check_output("sweep_unexpected", 64'(s_out_valid), 64'd0);
                    end else begin
                        e = s_sb.pop_front();
                        check_output($sformatf("product_w%0d", W), 64'(s_product), e.prod);
                        check_output($sformatf("latency_w%0d", W), 64'(cyc - e.acc_cyc), 64'(W));
                    end
                    s_seen = 1'b1;
                end
                s_out_ready = $urandom_range(0, 1) != 0;
                if (s_out_valid && s_out_ready) s_seen = 1'b0;
            end
        end
    end

    // Main sequence for the WIDTH=8 instance.
    initial begin
        int g;
        $display("[TB] seq_multiplier bench start");
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        apply_stimulus(8'd15, 8'd13, 1'b0);
        apply_stimulus(8'd255, 8'd255, 1'b0);
        apply_stimulus(8'hFD, 8'h05, 1'b1);
        apply_stimulus(8'h80, 8'h80, 1'b1);
        apply_stimulus(8'h80, 8'h01, 1'b1);
        apply_stimulus(8'h00, 8'h00, 1'b1);
        apply_stimulus(8'h00, 8'hA5, 1'b0);
        apply_stimulus(8'h7F, 8'h80, 1'b1);
        wait_idle();

        // Backpressure: result held for 20 cycles before release.
        bp_req = 20;
        apply_stimulus(8'hC8, 8'h37, 1'b1);
        wait_idle();
        bp_req = 0;

        // Reset during BUSY aborts without any output handshake.
        apply_stimulus(8'd9, 8'd7, 1'b0);
        wait_idle();
        @(negedge clk);
        a = 8'd15; b = 8'd13; is_signed = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_busy");
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check_output("no_valid_after_abort", 64'(out_valid), 64'd0);
        end
        apply_stimulus(8'd200, 8'd3, 1'b0);
        wait_idle();

        // Reset while DONE is being held by backpressure.
        bp_req = 1000;
        apply_stimulus(8'h81, 8'h7F, 1'b1);
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check_output("done_reached", 64'(out_valid), 64'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_done");
        @(negedge clk);
        rst = 1'b0;
        bp_req = 0;
        sb.delete();
        apply_stimulus(8'd3, 8'd5, 1'b0);

        // Random signed and unsigned traffic.
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(8'($urandom), 8'($urandom), 1'($urandom));
        end
        wait_idle();

        g = 0;
        while (sweep_done < 2 && g < 5000) begin
            @(negedge clk);
            g++;
        end
        check_output("sweep_finished", 64'(sweep_done), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
